// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle RV32I core.
// It selects the next PC, traps on misaligned targets, and handles debug halt/resume and instret.
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [63:0] instret,
  output logic        trap,
  output logic [31:0] epc,
  output logic [31:0] badaddr,
  output logic        halted
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [63:0] r_instret;
  logic        r_trap;
  logic [31:0] r_epc;
  logic [31:0] r_badaddr;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_tgt;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_fault;
  logic        w_update;

  // Only redirected targets can fault; the sequential path is always word aligned.
  function automatic logic f_misaligned(input logic redirect, input logic [31:0] tgt);
    return redirect && (tgt[1:0] != 2'b00);
  endfunction

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_tgt   = r_pc + imm;
  assign w_jalr_tgt = (rs1_data + imm) & 32'hFFFF_FFFE;

  always_comb begin
    w_redirect = 1'b0;
    w_next_pc  = w_pc_plus4;
    if (is_jalr) begin
      w_redirect = 1'b1;
      w_next_pc  = w_jalr_tgt;
    end else if (is_jal) begin
      w_redirect = 1'b1;
      w_next_pc  = w_pc_tgt;
    end else if (is_branch && branch_taken) begin
      w_redirect = 1'b1;
      w_next_pc  = w_pc_tgt;
    end
    w_fault = f_misaligned(w_redirect, w_next_pc);
  end

  // A halt request in RUN wins over the instruction update; a simultaneous
  // halt_req keeps HALT sticky even when resume is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_update    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else if (!stall) begin
          w_update = 1'b1;
        end
      end
      S_HALT: begin
        if (resume && !halt_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_instret <= 64'd0;
      r_trap    <= 1'b0;
      r_epc     <= 32'd0;
      r_badaddr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_trap  <= w_update && w_fault;
      if (w_update) begin
        if (w_fault) begin
          r_pc      <= TRAP_VECTOR;
          r_epc     <= r_pc;
          r_badaddr <= w_next_pc;
        end else begin
          r_pc      <= w_next_pc;
          r_instret <= r_instret + 64'd1;
        end
      end
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign instret  = r_instret;
  assign trap     = r_trap;
  assign epc      = r_epc;
  assign badaddr  = r_badaddr;
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes hand-computed expectations into a queue,
// and a monitor pops and compares them after each clock edge or asynchronous reset.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, is_branch, branch_taken, is_jal, is_jalr;
  logic [31:0] imm, rs1_data;
  logic        halt_req, resume;
  logic [31:0] pc, pc_plus4, epc, badaddr;
  logic [63:0] instret;
  logic        trap, halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instret;
    logic        trap;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        halted;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch),
    .branch_taken(branch_taken), .is_jal(is_jal), .is_jalr(is_jalr),
    .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .instret(instret), .trap(trap),
    .epc(epc), .badaddr(badaddr), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per clock edge or reset assertion.
  initial begin
    exp_t  e;
    string nm;
    logic [31:0] e_p4;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        e_p4 = e.pc + 32'd4;
        chk(nm, "pc",       {32'd0, pc},       {32'd0, e.pc});
        chk(nm, "pc_plus4", {32'd0, pc_plus4}, {32'd0, e_p4});
        chk(nm, "instret",  instret,           e.instret);
        chk(nm, "trap",     {63'd0, trap},     {63'd0, e.trap});
        chk(nm, "epc",      {32'd0, epc},      {32'd0, e.epc});
        chk(nm, "badaddr",  {32'd0, badaddr},  {32'd0, e.badaddr});
        chk(nm, "halted",   {63'd0, halted},   {63'd0, e.halted});
      end
    end
  end

  task automatic expect_state(input string nm, input logic [31:0] p, input logic [63:0] ir,
                              input logic t, input logic [31:0] ep, input logic [31:0] ba,
                              input logic h);
    exp_t e;
    e.pc = p; e.instret = ir; e.trap = t; e.epc = ep; e.badaddr = ba; e.halted = h;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Inputs are set at the falling edge; the expectation is for after the next rising edge.
  task automatic step(input string nm, input logic [31:0] p, input logic [63:0] ir,
                      input logic t, input logic [31:0] ep, input logic [31:0] ba,
                      input logic h);
    expect_state(nm, p, ir, t, ep, ba, h);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    stall = 0; is_branch = 0; branch_taken = 0; is_jal = 0; is_jalr = 0;
    imm = 32'd0; rs1_data = 32'd0; halt_req = 0; resume = 0;
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    step("rst_hold", 32'h0, 64'd0, 0, 32'h0, 32'h0, 0);

    rst_n = 1'b1;
    step("seq1", 32'h4, 64'd1, 0, 32'h0, 32'h0, 0);
    step("seq2", 32'h8, 64'd2, 0, 32'h0, 32'h0, 0);
    step("seq3", 32'hC, 64'd3, 0, 32'h0, 32'h0, 0);

    is_jal = 1; imm = 32'h34;
    step("jal_to_40", 32'h40, 64'd4, 0, 32'h0, 32'h0, 0);
    idle_in(); is_branch = 1; branch_taken = 1; imm = 32'hFFFF_FFF0;
    step("br_taken", 32'h30, 64'd5, 0, 32'h0, 32'h0, 0);
    idle_in(); is_jal = 1; imm = 32'h10;
    step("jal_back_40", 32'h40, 64'd6, 0, 32'h0, 32'h0, 0);
    idle_in(); is_branch = 1; branch_taken = 0; imm = 32'hFFFF_FFF0;
    step("br_not_taken", 32'h44, 64'd7, 0, 32'h0, 32'h0, 0);
    idle_in(); is_jal = 1; imm = 32'hFFFF_FFDC;
    step("jal_to_20", 32'h20, 64'd8, 0, 32'h0, 32'h0, 0);

    idle_in(); is_jalr = 1; rs1_data = 32'h1003; imm = 32'h0;
    step("jalr_fault", 32'h100, 64'd8, 1, 32'h20, 32'h1002, 0);
    rs1_data = 32'h1001;
    step("jalr_bit0_ok", 32'h1000, 64'd9, 0, 32'h20, 32'h1002, 0);
    idle_in(); is_jal = 1; imm = 32'h2;
    step("jal_fault", 32'h100, 64'd9, 1, 32'h1000, 32'h1002, 0);
    idle_in(); is_branch = 1; branch_taken = 1; imm = 32'h1;
    step("br_fault_b2b", 32'h100, 64'd9, 1, 32'h100, 32'h101, 0);
    idle_in();
    step("seq_after_trap", 32'h104, 64'd10, 0, 32'h100, 32'h101, 0);

    is_jalr = 1; is_jal = 1; is_branch = 1; branch_taken = 1; rs1_data = 32'h200; imm = 32'h8;
    step("prio_jalr", 32'h208, 64'd11, 0, 32'h100, 32'h101, 0);

    idle_in(); stall = 1; is_jal = 1; imm = 32'h10;
    step("stall1", 32'h208, 64'd11, 0, 32'h100, 32'h101, 0);
    step("stall2", 32'h208, 64'd11, 0, 32'h100, 32'h101, 0);
    stall = 0;
    step("stall_rel", 32'h218, 64'd12, 0, 32'h100, 32'h101, 0);
    imm = 32'hFFFF_FE68;
    step("jal_to_80", 32'h80, 64'd13, 0, 32'h100, 32'h101, 0);

    idle_in(); halt_req = 1; is_branch = 1; branch_taken = 1; imm = 32'h20;
    step("halt_enter", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    halt_req = 0;
    step("halt_c1", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    stall = 1;
    step("halt_c2", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    stall = 0; is_jal = 1; imm = 32'h3;
    step("halt_c3", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    halt_req = 1; resume = 1;
    step("halt_both", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    halt_req = 0; resume = 0;
    step("halt_c5", 32'h80, 64'd13, 0, 32'h100, 32'h101, 1);
    idle_in(); resume = 1;
    step("resume", 32'h80, 64'd13, 0, 32'h100, 32'h101, 0);
    resume = 0;
    step("post_resume", 32'h84, 64'd14, 0, 32'h100, 32'h101, 0);
    resume = 1;
    step("resume_in_run", 32'h88, 64'd15, 0, 32'h100, 32'h101, 0);

    idle_in(); is_jal = 1; imm = 32'hFFFF_FF74;
    step("jal_to_top", 32'hFFFF_FFFC, 64'd16, 0, 32'h100, 32'h101, 0);
    idle_in();
    step("pc_wrap", 32'h0, 64'd17, 0, 32'h100, 32'h101, 0);

    halt_req = 1; is_jal = 1; imm = 32'h2;
    step("halt_drop_fault", 32'h0, 64'd17, 0, 32'h100, 32'h101, 1);
    idle_in(); resume = 1;
    step("resume2", 32'h0, 64'd17, 0, 32'h100, 32'h101, 0);

    idle_in();
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    step("instret_wrap", 32'h4, 64'd0, 0, 32'h100, 32'h101, 0);

    halt_req = 1;
    step("halt_pre_rst", 32'h4, 64'd0, 0, 32'h100, 32'h101, 1);
    halt_req = 0;
    expect_state("async_rst", 32'h0, 64'd0, 0, 32'h0, 32'h0, 0);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 32'h4, 64'd1, 0, 32'h0, 32'h0, 0);

    budget = 0;
    while (q_exp.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (q_exp.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
